vexp_lanes: RTL and testbench

VEXP_LANES -- requirements
Module: vexp_lanes

---
 rtl/vexp_lanes.sv | 97 +++++++++
 tb/tb_vexp_lanes.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/vexp_lanes.sv
// vexp_lanes: LANES-wide bf16 exp(x) in three stages (convert, multiply by log2(e), pack).
// Define VEXP_LANES_FLAGS_EN to add per-lane ovf/unf outputs aligned with result.
module vexp_lanes #(
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [16*LANES-1:0]  operand,
  input  logic [LANES-1:0]     lane_mask,
  input  logic                 valid_in,
  output logic                 ready_in,
  output logic [16*LANES-1:0]  result,
  output logic                 valid_out,
  input  logic                 ready_out,
`ifdef VEXP_LANES_FLAGS_EN
  output logic [LANES-1:0]     ovf,
  output logic [LANES-1:0]     unf,
`endif
  output logic                 busy
);
  logic v1, v2, v3, en2, en3;
  logic [16*LANES-1:0] x_d, x1, r_d;
  logic [17*LANES-1:0] y_d, y2;
  logic [LANES-1:0] m1, m2, n1, n2, nan_d;
`ifdef VEXP_LANES_FLAGS_EN
  logic [LANES-1:0] ovf_d, unf_d;
`endif
  assign en3 = !v3 || ready_out;
  assign en2 = !v2 || en3;
  assign ready_in = !v1 || en2;
  assign valid_out = v3;
  assign busy = v1 | v2 | v3;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic sg;
    logic [7:0] e, mag;
    logic [15:0] sh;
    logic [16:0] y;
    logic signed [16:0] ex;
    logic ov, un;
    assign sg = operand[16*k+15];
    assign e = operand[16*k+7 +: 8];
    assign mag = {1'b1, operand[16*k +: 7]};
    assign sh = e >= 8'd126 ? {8'd0, mag} << (e - 8'd126) : {8'd0, mag} >> (8'd126 - e);
    assign x_d[16*k +: 16] = e == 8'd0 ? 16'd0 : e >= 8'd134 ? (sg ? 16'h8000 : 16'h7FFF) : sg ? -sh : sh;
    assign nan_d[k] = &e && |operand[16*k +: 7];
    // Only bits [25:9] of x*369 matter: integer part y[16:7], fraction top bits y[6:0]
    assign y_d[17*k +: 17] = 17'((26'($signed(x1[16*k +: 16])) * 26'sd369) >>> 9);
    assign y = y2[17*k +: 17];
    assign ex = $signed({{7{y[16]}}, y[16:7]}) + 17'sd127;
    assign ov = ex >= 17'sd255;
    assign un = ex <= 17'sd0;
    assign r_d[16*k +: 16] = !m2[k] ? 16'h0000 : n2[k] ? 16'h7FC0 : un ? 16'h0000 :
                             ov ? 16'h7F80 : {1'b0, ex[7:0], y[6:0]};
`ifdef VEXP_LANES_FLAGS_EN
    assign ovf_d[k] = m2[k] && !n2[k] && ov;
    assign unf_d[k] = m2[k] && !n2[k] && un;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {v1, v2, v3} <= '0;
      x1 <= '0;
      m1 <= '0;
      n1 <= '0;
      y2 <= '0;
      m2 <= '0;
      n2 <= '0;
      result <= '0;
    end else begin
      if (ready_in) begin
        v1 <= valid_in;
        x1 <= x_d;
        m1 <= lane_mask;
        n1 <= nan_d;
      end
      if (en2) begin
        v2 <= v1;
        y2 <= y_d;
        m2 <= m1;
        n2 <= n1;
      end
      if (en3) begin
        v3 <= v2;
        result <= r_d;
      end
    end
`ifdef VEXP_LANES_FLAGS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ovf <= '0;
      unf <= '0;
    end else if (en3) begin
      ovf <= ovf_d;
      unf <= unf_d;
    end
`endif
endmodule

// File: tb/tb_vexp_lanes.sv
// tb_vexp_lanes: table vectors, corner sequences and randomized traffic against an arithmetic model.
module tb_vexp_lanes;
  logic clk = 0, rst = 1;
  logic [63:0] operand = '0, result;
  logic [3:0] lane_mask = '0;
  logic valid_in = 0, ready_in, valid_out, ready_out = 0, busy;
`ifdef VEXP_LANES_FLAGS_EN
  logic [3:0] ovf, unf;
`endif
  int checks = 0, errors = 0, n_acc = 0, n_out = 0;
  logic [63:0] q[$];

  vexp_lanes #(.LANES(4)) dut (
    .clk(clk), .rst(rst), .operand(operand), .lane_mask(lane_mask), .valid_in(valid_in),
    .ready_in(ready_in), .result(result), .valid_out(valid_out), .ready_out(ready_out),
`ifdef VEXP_LANES_FLAGS_EN
    .ovf(ovf), .unf(unf),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] op;
    logic [3:0]  mask;
    logic [63:0] exp;
    logic [3:0]  ovf;
    logic [3:0]  unf;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // exp(v) ~ 2^(v*log2 e), computed with plain integer arithmetic on the real value's Q8.8 form
  function automatic logic [15:0] model(input logic [15:0] a, input logic m);
    int e, mag, x, y, i, f, ex;
    logic [15:0] r;
    e = int'(a[14:7]);
    mag = 128 + int'(a[6:0]);
    if (!m) return 16'h0000;
    if (e == 255 && a[6:0] != 0) return 16'h7FC0;
    if (e == 0) x = 0;
    else if (e >= 134) x = a[15] ? -32768 : 32767;
    else begin
      if (e >= 126) x = mag * (1 << (e - 126));
      else x = (126 - e > 8) ? 0 : mag / (1 << (126 - e));
      if (a[15]) x = -x;
    end
    y = (x * 369) >>> 8;
    i = y >>> 8;
    f = y & 255;
    ex = i + 127;
    if (ex <= 0) return 16'h0000;
    if (ex >= 255) return 16'h7F80;
    r = {1'b0, ex[7:0], f[7:1]};
    return r;
  endfunction

  function automatic logic [63:0] model_vec(input logic [63:0] op, input logic [3:0] mk);
    logic [63:0] r;
    for (int k = 0; k < 4; k++) r[16*k +: 16] = model(op[16*k +: 16], mk[k]);
    return r;
  endfunction

  function automatic logic [15:0] rand_bf16();
    logic [15:0] sp[6] = '{16'h7F80, 16'hFF80, 16'h7FC1, 16'h0000, 16'h4300, 16'hC2FF};
    logic [7:0] e;
    case ($urandom % 8)
      0: return 16'($urandom);
      1: return sp[$urandom % 6];
      default: begin
        e = 8'(115 + $urandom % 22);
        return {1'($urandom), e, 7'($urandom)};
      end
    endcase
  endfunction

  function automatic logic [63:0] rand_vec();
    return {rand_bf16(), rand_bf16(), rand_bf16(), rand_bf16()};
  endfunction

  // One cycle: drive, score output/input transfers, advance to just after the next edge
  task automatic tick(input logic vi, input logic [63:0] op, input logic [3:0] mk, input logic ro);
    valid_in = vi;
    operand = op;
    lane_mask = mk;
    ready_out = ro;
    #1;
    if (valid_out && ready_out) begin
      n_out++;
      if (q.size() == 0) chk("unexpected_output", 64'd1, 64'd0);
      else chk("scoreboard", result, q.pop_front());
    end else if (valid_out && q.size() > 0) chk("hold", result, q[0]);
    if (valid_in && ready_in) begin
      n_acc++;
      q.push_back(model_vec(op, mk));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 20 && q.size() > 0; i++) tick(0, '0, '0, 1);
    chk(nm, 64'(q.size()), 64'd0);
  endtask

  vec_t tab[5];
  int a0, o0, lows;
  logic [63:0] v;

  initial begin
    tab[0] = '{64'hC2C8_42C8_3F80_0000, 4'hF, 64'h0000_7F80_4038_3F80, 4'b0100, 4'b1000};
    tab[1] = '{64'hBF80_3F80_0000_7FC1, 4'b1011, 64'h3EC7_0000_3F80_7FC0, 4'b0000, 4'b0000};
    tab[2] = '{64'h0001_4000_FF80_7F80, 4'hF, 64'h3F80_40F1_0000_7F80, 4'b0001, 4'b0010};
    tab[3] = '{64'hC2C8_42C8_3F80_0000, 4'h0, 64'h0000_0000_0000_0000, 4'b0000, 4'b0000};
    tab[4] = '{64'hC300_4300_BC00_3C00, 4'hF, 64'h0000_7F80_3F7E_3F81, 4'b0100, 4'b1000};
    #12;
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_ready_in", 64'(ready_in), 64'd1);
    @(posedge clk);
    #1;
    rst = 0;
    for (int t = 0; t < 5; t++) begin
      tick(1, tab[t].op, tab[t].mask, 1);
      tick(0, '0, '0, 1);
      chk("tab_latency_early", 64'(valid_out), 64'd0);
      tick(0, '0, '0, 1);
      chk("tab_valid", 64'(valid_out), 64'd1);
      chk("tab_result", result, tab[t].exp);
`ifdef VEXP_LANES_FLAGS_EN
      chk("tab_ovf", 64'(ovf), 64'(tab[t].ovf));
      chk("tab_unf", 64'(unf), 64'(tab[t].unf));
`endif
      drain("tab_drain");
    end
    // back-to-back stream of 8
    o0 = n_out;
    lows = 0;
    for (int i = 0; i < 8; i++) begin
      if (!ready_in) lows++;
      tick(1, rand_vec(), 4'hF, 1);
    end
    for (int i = 0; i < 3; i++) tick(0, '0, '0, 1);
    chk("stream_outputs", 64'(n_out - o0), 64'd8);
    chk("stream_ready_low", 64'(lows), 64'd0);
    chk("stream_empty", 64'(q.size()), 64'd0);
    // backpressure: fill and hold
    a0 = n_acc;
    o0 = n_out;
    for (int i = 0; i < 5; i++) tick(1, rand_vec(), 4'($urandom), 0);
    ready_out = 0;
    valid_in = 1;
    #1;
    chk("stall_accepts", 64'(n_acc - a0), 64'd3);
    chk("stall_ready_in", 64'(ready_in), 64'd0);
    chk("stall_busy", 64'(busy), 64'd1);
    chk("stall_valid_out", 64'(valid_out), 64'd1);
    chk("stall_result", result, q[0]);
    for (int i = 0; i < 3; i++) tick(0, '0, '0, 0);
    chk("stall_frozen", result, q[0]);
    drain("stall_drain");
    chk("stall_outputs", 64'(n_out - o0), 64'd3);
    // reset with two vectors in flight
    tick(1, rand_vec(), 4'hF, 1);
    tick(1, rand_vec(), 4'hF, 1);
    rst = 1;
    #1;
    chk("mid_rst_valid_out", 64'(valid_out), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ready_in", 64'(ready_in), 64'd1);
    q.delete();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 0;
    v = 64'h4000_3F80_0000_BF80;
    tick(1, v, 4'hF, 1);
    tick(0, '0, '0, 1);
    chk("post_rst_early", 64'(valid_out), 64'd0);
    tick(0, '0, '0, 1);
    chk("post_rst_valid", 64'(valid_out), 64'd1);
    chk("post_rst_result", result, 64'h40F1_4038_3F80_3EC7);
    drain("post_rst_drain");
    // randomized traffic with random backpressure
    a0 = n_acc;
    o0 = n_out;
    for (int i = 0; i < 400; i++) tick($urandom % 4 != 0, rand_vec(), 4'($urandom), $urandom % 3 != 0);
    drain("rand_drain");
    chk("rand_count", 64'(n_out - o0), 64'(n_acc - a0));
    chk("final_busy", 64'(busy), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
